// File: rtl/operand2_imm_encoder_pkg.sv
// Shared types and constants for the operand-2 immediate encoder.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } enc_state_t;

    localparam int ROT_STEPS = 16;
    localparam int IMM_W     = 8;
    localparam int ROT_W     = 4;

    // Highest rotate field value; the search wraps to the inverse pass after it.
    localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT_STEPS - 1);

    // The rotate field counts bit pairs, so the shift amount is twice the field.
    function automatic logic [4:0] shift_amt(input logic [ROT_W-1:0] rot);
        return {rot, 1'b0};
    endfunction

endpackage

// File: rtl/operand2_imm_encoder_rol32.sv
// Combinational 32-bit rotate-left; amt wraps modulo 32.
module rol32 (
    input  logic [31:0] data,
    input  logic [4:0]  amt,
    output logic [31:0] rotated
);

    // Each output bit selects the source bit amt positions below it (mod 32).
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_bit
            localparam logic [4:0] POS = 5'(gi);
            logic [4:0] src_idx;
            assign src_idx     = POS - amt;
            assign rotated[gi] = data[src_idx];
        end
    endgenerate

endmodule

// File: rtl/operand2_imm_encoder.sv
// Searches for an imm8/rot4 pair (optionally of the inverted value) that
// expands to a given 32-bit constant, trying one rotation per cycle.
module operand2_imm_encoder
    import cpu_pkg::*;
#(
    parameter bit SEARCH_INVERTED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value_in,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic [7:0]  imm8_out,
    output logic [3:0]  rot4_out,
    output logic        inv_out
);

    enc_state_t       state_reg, state_next;
    logic [31:0]      val_reg, val_next;
    logic [ROT_W-1:0] rot_reg, rot_next;
    logic             inv_reg, inv_next;

    logic             valid_reg, valid_next;
    logic [IMM_W-1:0] imm8_reg, imm8_next;
    logic [ROT_W-1:0] rot4_reg, rot4_next;
    logic             inv_out_reg, inv_out_next;

    logic [31:0]      src;
    logic [31:0]      cand;
    logic             hit;

    // Rotating left undoes the ROR of the expansion path; a hit leaves only
    // the low byte populated.
    assign src = inv_reg ? ~val_reg : val_reg;

    rol32 u_rol (
        .data    (src),
        .amt     (shift_amt(rot_reg)),
        .rotated (cand)
    );

    assign hit = (cand[31:IMM_W] == '0);

    // State, search registers and result registers; reset aborts any search.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            val_reg     <= '0;
            rot_reg     <= '0;
            inv_reg     <= 1'b0;
            valid_reg   <= 1'b0;
            imm8_reg    <= '0;
            rot4_reg    <= '0;
            inv_out_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            val_reg     <= val_next;
            rot_reg     <= rot_next;
            inv_reg     <= inv_next;
            valid_reg   <= valid_next;
            imm8_reg    <= imm8_next;
            rot4_reg    <= rot4_next;
            inv_out_reg <= inv_out_next;
        end
    end

    // Next-state logic: accept a request, step through candidates in search
    // order (direct rot 0..15, then inverted rot 0..15), publish the result.
    always_comb begin
        state_next   = state_reg;
        val_next     = val_reg;
        rot_next     = rot_reg;
        inv_next     = inv_reg;
        valid_next   = valid_reg;
        imm8_next    = imm8_reg;
        rot4_next    = rot4_reg;
        inv_out_next = inv_out_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    val_next   = value_in;
                    rot_next   = '0;
                    inv_next   = 1'b0;
                    state_next = SEARCH;
                end
            end
            SEARCH: begin
                if (hit) begin
                    valid_next   = 1'b1;
                    imm8_next    = cand[IMM_W-1:0];
                    rot4_next    = rot_reg;
                    inv_out_next = inv_reg;
                    state_next   = DONE;
                end else if (rot_reg != ROT_LAST) begin
                    rot_next = rot_reg + 1'b1;
                end else if (!inv_reg && SEARCH_INVERTED) begin
                    inv_next = 1'b1;
                    rot_next = '0;
                end else begin
                    valid_next   = 1'b0;
                    imm8_next    = '0;
                    rot4_next    = '0;
                    inv_out_next = 1'b0;
                    state_next   = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy     = (state_reg != IDLE);
    assign done     = (state_reg == DONE);
    assign valid    = valid_reg;
    assign imm8_out = imm8_reg;
    assign rot4_out = rot4_reg;
    assign inv_out  = inv_out_reg;

endmodule

// File: tb/tb_operand2_imm_encoder.sv
// Bench for operand2_imm_encoder: directed vector table, corner sequences and a
// random sweep, checked against an exhaustive forward-expansion model.
module tb_operand2_imm_encoder;

    typedef struct packed {
        logic       valid;
        logic [7:0] imm;
        logic [3:0] rot;
        logic       inv;
        logic [7:0] lat;
    } exp_t;

    typedef struct {
        logic [31:0] value;
        exp_t        e1;
        exp_t        e0;
        int          inject;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] value_in;

    logic        busy1, done1, valid1, inv1;
    logic [7:0]  imm1;
    logic [3:0]  rot1;
    logic        busy0, done0, valid0, inv0;
    logic [7:0]  imm0;
    logic [3:0]  rot0;

    int asserts = 0;
    int fails   = 0;

    exp_t q1[$];
    exp_t q0[$];

    operand2_imm_encoder #(.SEARCH_INVERTED(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .value_in(value_in),
        .busy(busy1), .done(done1), .valid(valid1),
        .imm8_out(imm1), .rot4_out(rot1), .inv_out(inv1)
    );

    operand2_imm_encoder #(.SEARCH_INVERTED(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .value_in(value_in),
        .busy(busy0), .done(done0), .valid(valid0),
        .imm8_out(imm0), .rot4_out(rot0), .inv_out(inv0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(logic v, logic [7:0] imm, logic [3:0] rot, logic inv, int lat);
        exp_t e;
        e.valid = v;
        e.imm   = imm;
        e.rot   = rot;
        e.inv   = inv;
        e.lat   = 8'(lat);
        return e;
    endfunction

    function automatic logic [31:0] ror32(logic [31:0] x, int amt);
        if (amt == 0) return x;
        return (x >> amt) | (x << (32 - amt));
    endfunction

    // Forward model: expand every imm8/rot pair and take the first match in
    // search order; done latency is 2 + candidate index.
    function automatic exp_t model(logic [31:0] v, bit search_inv);
        logic [31:0] s;
        for (int p = 0; p < 2; p++) begin
            if (p == 1 && !search_inv) break;
            s = (p == 1) ? ~v : v;
            for (int r = 0; r < 16; r++) begin
                for (int i = 0; i < 256; i++) begin
                    if (ror32(32'(i), 2 * r) == s)
                        return mk(1'b1, 8'(i), 4'(r), p[0], 2 + 16 * p + r);
                end
            end
        end
        return mk(1'b0, 8'h00, 4'h0, 1'b0, search_inv ? 33 : 17);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cmp_res(string tag, exp_t e, logic [31:0] v, logic vl, logic [7:0] imm,
                           logic [3:0] rot, logic inv, int cyc);
        chk({tag, "_valid"}, 32'(vl), 32'(e.valid));
        chk({tag, "_imm8"},  32'(imm), 32'(e.imm));
        chk({tag, "_rot4"},  32'(rot), 32'(e.rot));
        chk({tag, "_inv"},   32'(inv), 32'(e.inv));
        chk({tag, "_latency"}, 32'(cyc), 32'(e.lat));
        if (vl === 1'b1)
            chk({tag, "_ror_invariant"}, ror32(32'(imm), 2 * int'(rot)), inv ? ~v : v);
    endtask

    // One request through both instances; inject>0 pulses start again in that
    // cycle and keeps watching for a spurious second done.
    task automatic run_txn(logic [31:0] v, exp_t e1, exp_t e0, int inject);
        int   cyc;
        bit   got1, got0;
        exp_t e;
        @(negedge clk);
        value_in = v;
        start    = 1'b1;
        q1.push_back(e1);
        q0.push_back(e0);
        cyc  = 0;
        got1 = 0;
        got0 = 0;
        while (cyc < 45 && (inject != 0 || !(got1 && got0))) begin
            @(posedge clk);
            #1;
            cyc++;
            start    = (inject != 0 && cyc == inject);
            value_in = cyc[0] ? ~v : v;
            if (done1) begin
                if (got1 || q1.size() == 0) begin
                    chk("extra_done_inv1", 32'(cyc), 32'(0));
                end else begin
                    e = q1.pop_front();
                    cmp_res("inv1", e, v, valid1, imm1, rot1, inv1, cyc);
                    got1 = 1;
                end
            end
            if (done0) begin
                if (got0 || q0.size() == 0) begin
                    chk("extra_done_inv0", 32'(cyc), 32'(0));
                end else begin
                    e = q0.pop_front();
                    cmp_res("inv0", e, v, valid0, imm0, rot0, inv0, cyc);
                    got0 = 1;
                end
            end
        end
        start = 1'b0;
        chk("done_seen_inv1", 32'(got1), 32'(1));
        chk("done_seen_inv0", 32'(got0), 32'(1));
        q1.delete();
        q0.delete();
        if (inject == 0) begin
            @(posedge clk);
            #1;
            chk("done_single_cycle", {30'b0, done1, done0}, 32'(0));
        end
        $display("txn value=0x%08h inv1:valid=%0b imm8=0x%02h rot4=%0d inv=%0b inv0:valid=%0b imm8=0x%02h rot4=%0d",
                 v, valid1, imm1, rot1, inv1, valid0, imm0, rot0);
    endtask

    vec_t vecs[7];

    initial begin
        logic [31:0] v;
        int          dcount;

        vecs[0] = '{32'h000000FF, mk(1, 8'hFF, 4'd0,  0, 2),  mk(1, 8'hFF, 4'd0,  0, 2),  0};
        vecs[1] = '{32'hFF000000, mk(1, 8'hFF, 4'd4,  0, 6),  mk(1, 8'hFF, 4'd4,  0, 6),  0};
        vecs[2] = '{32'hF000000F, mk(1, 8'hFF, 4'd2,  0, 4),  mk(1, 8'hFF, 4'd2,  0, 4),  0};
        vecs[3] = '{32'hFFFFFF00, mk(1, 8'hFF, 4'd0,  1, 18), mk(0, 8'h00, 4'd0,  0, 17), 0};
        vecs[4] = '{32'h00000101, mk(0, 8'h00, 4'd0,  0, 33), mk(0, 8'h00, 4'd0,  0, 17), 5};
        vecs[5] = '{32'h00000000, mk(1, 8'h00, 4'd0,  0, 2),  mk(1, 8'h00, 4'd0,  0, 2),  0};
        vecs[6] = '{32'h000003FC, mk(1, 8'hFF, 4'd15, 0, 17), mk(1, 8'hFF, 4'd15, 0, 17), 0};

        reset    = 1'b1;
        start    = 1'b0;
        value_in = 32'h0;
        #3;
        chk("reset_outputs_inv1", {18'b0, busy1, done1, valid1, imm1, rot1, inv1}, 32'(0));
        chk("reset_outputs_inv0", {18'b0, busy0, done0, valid0, imm0, rot0, inv0}, 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed table; the last entry leaves imm8=0xFF for the abort test.
        for (int i = 0; i < 7; i++)
            run_txn(vecs[i].value, vecs[i].e1, vecs[i].e0, vecs[i].inject);

        // Reset mid-search: outputs clear asynchronously, aborted request never completes.
        @(negedge clk);
        value_in = 32'h00000101;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("busy_before_abort", 32'(busy1), 32'(1));
        chk("hold_imm8_before_abort", 32'(imm1), 32'hFF);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_outputs_inv1", {18'b0, busy1, done1, valid1, imm1, rot1, inv1}, 32'(0));
        chk("abort_outputs_inv0", {18'b0, busy0, done0, valid0, imm0, rot0, inv0}, 32'(0));
        @(negedge clk);
        reset  = 1'b0;
        dcount = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done1 || done0) dcount++;
        end
        chk("no_done_after_abort", 32'(dcount), 32'(0));
        $display("abort sequence: done pulses after reset=%0d", dcount);
        run_txn(32'h0, mk(1, 8'h00, 4'd0, 0, 2), mk(1, 8'h00, 4'd0, 0, 2), 0);

        // Random sweep: mixture of arbitrary, encodable and inverse-encodable values.
        for (int n = 0; n < 1500; n++) begin
            case (n % 3)
                0:       v = $urandom;
                1:       v = ror32(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)));
                default: v = ~ror32(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)));
            endcase
            run_txn(v, model(v, 1'b1), model(v, 1'b0), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #5000000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
